// File: rtl/ntru_arith_pkg.sv
// Shared types and helpers for the ternary convolution engine.
// Latency: none (types and a combinational index helper only).
// Backpressure: not applicable.
package ntru_arith_pkg;

    localparam int DEF_COEF_W = 13;

    typedef logic [DEF_COEF_W-1:0] coef_t;

    // Ternary coefficient: nz=0 means 0, otherwise neg selects -1 / +1.
    typedef struct packed {
        logic nz;
        logic neg;
    } tern_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_H,
        MAC_WAIT,
        MAC_SWEEP,
        DRAIN
    } state_e;

    // (k - j) mod n for 0 <= k, j < n: one conditional add, no divider.
    function automatic int wrap_idx(input int k, input int j, input int n);
        int d;
        d = k - j;
        if (d < 0) begin
            d = d + n;
        end
        return d;
    endfunction

endpackage

// File: rtl/tern_lane_alu.sv
// One accumulator lane: acc + h, acc - h, or acc unchanged, all mod 2^COEF_W.
// Latency: combinational.
// Backpressure: none; the caller decides when to write the result back.
module tern_lane_alu #(
    parameter int COEF_W = 13
) (
    input  logic [COEF_W-1:0] acc_i,
    input  logic [COEF_W-1:0] h_i,
    input  logic              en_i,
    input  logic              neg_i,
    output logic [COEF_W-1:0] acc_next_o
);

    logic [COEF_W-1:0] h_cond;
    logic [COEF_W-1:0] cin;

    // Negation as invert plus carry-in so the lane is a single adder.
    assign h_cond     = h_i ^ {COEF_W{neg_i}};
    assign cin        = {{(COEF_W-1){1'b0}}, neg_i};
    assign acc_next_o = en_i ? (acc_i + h_cond + cin) : acc_i;

endmodule

// File: rtl/ternary_conv_mac.sv
// Cyclic convolution e = h * r mod (2^COEF_W, x^N - 1) with ternary r, LANES accumulators per cycle.
// Latency: N load + N r beats + nz*ceil(N/LANES) sweep + N drain cycles without stalls.
// Backpressure: valid/ready on h, r and e; a stalled handshake holds all state, no extra bubbles.
module ternary_conv_mac
    import ntru_arith_pkg::*;
#(
    parameter int COEF_W = 13,
    parameter int N      = 701,
    parameter int LANES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic              h_valid,
    output logic              h_ready,
    input  logic [COEF_W-1:0] h_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic              r_nz,
    input  logic              r_neg,
    output logic              e_valid,
    input  logic              e_ready,
    output logic [COEF_W-1:0] e_data,
    output logic              done
);

    localparam int              IW      = $clog2(N + 1);
    localparam logic [IW-1:0]   LAST    = IW'(N - 1);
    localparam logic [IW-1:0]   ONE     = IW'(1);
    localparam logic [IW:0]     N_X     = (IW + 1)'(N);
    localparam logic [IW:0]     LANES_X = (IW + 1)'(LANES);

    state_e            state_q, state_d;
    logic [IW-1:0]     load_idx_q, load_idx_d;
    logic [IW-1:0]     j_q, j_d;
    logic [IW-1:0]     c_q, c_d;
    logic [IW-1:0]     out_idx_q, out_idx_d;
    logic              neg_q, neg_d;

    logic [COEF_W-1:0] h_q   [N];
    logic [COEF_W-1:0] acc_q [N];

    tern_t             r_in;
    logic              h_fire;
    logic              clear_acc;
    logic              last_chunk;

    logic [LANES-1:0]  lane_act;
    logic [IW-1:0]     lane_k   [LANES];
    logic [IW-1:0]     lane_h   [LANES];
    logic [COEF_W-1:0] lane_sum [LANES];

    assign r_in       = '{nz: r_nz, neg: r_neg};
    assign h_fire     = (state_q == LOAD_H) && h_valid;
    assign clear_acc  = (state_q == IDLE) && start;
    assign last_chunk = ({1'b0, c_q} + LANES_X) >= N_X;

    assign busy    = (state_q != IDLE);
    assign h_ready = (state_q == LOAD_H);
    assign r_ready = (state_q == MAC_WAIT);
    assign e_valid = (state_q == DRAIN);
    assign e_data  = (state_q == DRAIN) ? acc_q[out_idx_q] : '0;
    assign done    = (state_q == DRAIN) && e_ready && (out_idx_q == LAST);

    // Lane l handles coefficient k = c + l; lanes past N in the last chunk stay idle.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW:0] k_x;
        assign k_x         = {1'b0, c_q} + (IW + 1)'(l);
        assign lane_act[l] = (state_q == MAC_SWEEP) && (k_x < N_X);
        assign lane_k[l]   = lane_act[l] ? k_x[IW-1:0] : '0;
        assign lane_h[l]   = lane_act[l] ? IW'(wrap_idx(int'(k_x), int'(j_q), N)) : '0;

        tern_lane_alu #(.COEF_W(COEF_W)) u_alu (
            .acc_i      (acc_q[lane_k[l]]),
            .h_i        (h_q[lane_h[l]]),
            .en_i       (lane_act[l]),
            .neg_i      (neg_q),
            .acc_next_o (lane_sum[l])
        );
    end

    // Next-state logic for the control FSM and its counters.
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        j_d        = j_q;
        c_d        = c_q;
        out_idx_d  = out_idx_q;
        neg_d      = neg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_H;
                    load_idx_d = '0;
                    j_d        = '0;
                    c_d        = '0;
                    out_idx_d  = '0;
                end
            end
            LOAD_H: begin
                if (h_valid) begin
                    if (load_idx_q == LAST) begin
                        load_idx_d = '0;
                        j_d        = '0;
                        state_d    = MAC_WAIT;
                    end else begin
                        load_idx_d = load_idx_q + ONE;
                    end
                end
            end
            MAC_WAIT: begin
                if (r_valid) begin
                    if (r_in.nz) begin
                        neg_d   = r_in.neg;
                        c_d     = '0;
                        state_d = MAC_SWEEP;
                    end else begin
                        j_d = j_q + ONE;
                        if (j_q == LAST) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            MAC_SWEEP: begin
                if (last_chunk) begin
                    c_d     = '0;
                    j_d     = j_q + ONE;
                    state_d = (j_q == LAST) ? DRAIN : MAC_WAIT;
                end else begin
                    c_d = c_q + LANES_X[IW-1:0];
                end
            end
            DRAIN: begin
                if (e_ready) begin
                    if (out_idx_q == LAST) begin
                        out_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        out_idx_d = out_idx_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_idx_q <= '0;
            j_q        <= '0;
            c_q        <= '0;
            out_idx_q  <= '0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            j_q        <= j_d;
            c_q        <= c_d;
            out_idx_q  <= out_idx_d;
            neg_q      <= neg_d;
        end
    end

    // h storage; only overwritten by the next load, so no reset needed.
    always_ff @(posedge clk) begin
        if (h_fire) begin
            h_q[load_idx_q] <= h_data;
        end
    end

    // Accumulators: cleared by reset or start, written by active lanes during a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
        end else if (clear_acc) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_act[l]) begin
                    acc_q[lane_k[l]] <= lane_sum[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_ternary_conv_mac.sv
// Randomised self-checking bench: a small N=5/LANES=2 instance and a full N=701/LANES=8 instance.
// Expected results come from a direct cyclic-convolution sum over the ternary r vector.
// Inputs are driven on the falling edge and outputs observed 1 time unit later.
module tb_ternary_conv_mac;

    localparam int CW = 13;
    localparam int SN = 5;
    localparam int SL = 2;
    localparam int BN = 701;
    localparam int BL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance
    logic          rst, start, h_valid, r_valid, r_nz, r_neg, e_ready;
    logic [CW-1:0] h_data;
    logic          busy, h_ready, r_ready, e_valid, done;
    logic [CW-1:0] e_data;

    // Large instance
    logic          b_rst, b_start, b_h_valid, b_r_valid, b_r_nz, b_r_neg, b_e_ready;
    logic [CW-1:0] b_h_data;
    logic          b_busy, b_h_ready, b_r_ready, b_e_valid, b_done;
    logic [CW-1:0] b_e_data;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int hv[];
    int rv[];
    int ev[];

    ternary_conv_mac #(.COEF_W(CW), .N(SN), .LANES(SL)) u_small (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_nz(r_nz), .r_neg(r_neg),
        .e_valid(e_valid), .e_ready(e_ready), .e_data(e_data), .done(done)
    );

    ternary_conv_mac #(.COEF_W(CW), .N(BN), .LANES(BL)) u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy),
        .h_valid(b_h_valid), .h_ready(b_h_ready), .h_data(b_h_data),
        .r_valid(b_r_valid), .r_ready(b_r_ready), .r_nz(b_r_nz), .r_neg(b_r_neg),
        .e_valid(b_e_valid), .e_ready(b_e_ready), .e_data(b_e_data), .done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // e_i = sum_j r_j * h_{(i-j) mod n}, reduced mod 2^CW.
    function automatic void model(input int n);
        ev = new[n];
        for (int i = 0; i < n; i++) begin
            longint s = 0;
            for (int j = 0; j < n; j++) begin
                int d = (i - j) % n;
                if (d < 0) d += n;
                s += longint'(rv[j]) * longint'(hv[d]);
            end
            ev[i] = int'(s & 64'h1FFF);
        end
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load_h(input bit stall);
        int i = 0;
        int g = 0;
        while (i < SN && g < 1000) begin
            @(negedge clk);
            h_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            h_data  = CW'(hv[i]);
            #1;
            if (h_valid && h_ready) i++;
            g++;
        end
        @(negedge clk);
        h_valid = 1'b0;
        chk("h_beats", i, SN);
    endtask

    task automatic feed_r(input bit stall, output int sweeps);
        int i = 0;
        int g = 0;
        sweeps = 0;
        while (!e_valid && g < 2000) begin
            @(negedge clk);
            if (i < SN) begin
                r_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                r_nz    = (rv[i] != 0);
                r_neg   = (rv[i] < 0);
            end else begin
                r_valid = 1'b0;
            end
            #1;
            if (r_valid && r_ready) i++;
            if (busy && !h_ready && !r_ready && !e_valid) sweeps++;
            g++;
        end
        r_valid = 1'b0;
        chk("r_beats", i, SN);
        chk("drain_reached", e_valid, 1);
    endtask

    task automatic drain(input bit stall);
        int i = 0;
        int g = 0;
        bit was_stalled = 0;
        logic [CW-1:0] held = '0;
        done_cnt = 0;
        while (i < SN && g < 2000) begin
            @(negedge clk);
            e_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (e_valid) begin
                if (was_stalled) chk("e_hold", e_data, held);
                if (done) done_cnt++;
                if (e_ready) begin
                    chk($sformatf("e[%0d]", i), e_data, ev[i]);
                    i++;
                    was_stalled = 0;
                end else begin
                    was_stalled = 1;
                    held = e_data;
                end
            end
            g++;
        end
        @(negedge clk);
        e_ready = 1'b0;
        #1;
        chk("drain_beats", i, SN);
        chk("done_count", done_cnt, 1);
        chk("e_valid_drop", e_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run_small(input bit stall);
        int sweeps;
        int nz = 0;
        foreach (rv[j]) if (rv[j] != 0) nz++;
        model(SN);
        do_start();
        load_h(stall);
        feed_r(stall, sweeps);
        chk("sweep_cycles", sweeps, nz * ((SN + SL - 1) / SL));
        drain(stall);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; h_valid = 1'b0; r_valid = 1'b0;
        r_nz = 1'b0; r_neg = 1'b0; e_ready = 1'b0; h_data = '0;
        b_rst = 1'b1; b_start = 1'b0; b_h_valid = 1'b0; b_r_valid = 1'b0;
        b_r_nz = 1'b0; b_r_neg = 1'b0; b_e_ready = 1'b0; b_h_data = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_h_ready", h_ready, 0);
        chk("rst_r_ready", r_ready, 0);
        chk("rst_e_valid", e_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_e_data", e_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Identity, rotation, negation
        hv = '{1, 2, 3, 4, 5};
        rv = '{1, 0, 0, 0, 0};
        run_small(0);
        rv = '{0, 1, 0, 0, 0};
        run_small(0);
        rv = '{-1, 0, 0, 0, 0};
        run_small(0);

        // Modular wrap in both directions
        hv = '{8191, 8191, 8191, 8191, 8191};
        rv = '{1, 1, 1, 1, 1};
        run_small(0);
        rv = '{-1, -1, -1, -1, -1};
        run_small(0);

        // Backpressure with mixed r, then fully random vectors
        hv = new[SN];
        foreach (hv[i]) hv[i] = int'($urandom_range(0, 8191));
        rv = '{1, -1, 0, 1, 0};
        run_small(1);
        for (int t = 0; t < 3; t++) begin
            foreach (hv[i]) hv[i] = int'($urandom_range(0, 8191));
            foreach (rv[i]) rv[i] = int'($urandom_range(0, 2)) - 1;
            run_small(1);
        end

        // Reset in the middle of a sweep
        hv = '{1, 2, 3, 4, 5};
        do_start();
        load_h(0);
        @(negedge clk);
        r_valid = 1'b1; r_nz = 1'b1; r_neg = 1'b0;
        @(negedge clk);
        r_valid = 1'b0;
        #1;
        chk("in_sweep", {busy, h_ready, r_ready, e_valid}, 4'b1000);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_h_ready", h_ready, 0);
        chk("midrst_r_ready", r_ready, 0);
        chk("midrst_e_valid", e_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_e_data", e_data, 0);
        @(negedge clk);
        rst = 1'b0;
        rv = '{1, 0, 0, 0, 0};
        run_small(0);

        // Full-size instance with random h and sparse random r
        begin
            int i;
            int g;
            int nz;
            int sweeps;
            hv = new[BN];
            rv = new[BN];
            nz = 0;
            foreach (hv[k]) hv[k] = int'($urandom_range(0, 8191));
            foreach (rv[k]) begin
                rv[k] = ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 1) ? -1 : 1) : 0;
                if (rv[k] != 0) nz++;
            end
            model(BN);
            @(negedge clk);
            b_rst = 1'b0;
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            i = 0; g = 0;
            while (i < BN && g < 5000) begin
                @(negedge clk);
                b_h_valid = ($urandom_range(0, 3) != 0);
                b_h_data  = CW'(hv[i]);
                #1;
                if (b_h_valid && b_h_ready) i++;
                g++;
            end
            @(negedge clk);
            b_h_valid = 1'b0;
            chk("big_h_beats", i, BN);
            i = 0; g = 0; sweeps = 0;
            while (!b_e_valid && g < 40000) begin
                @(negedge clk);
                if (i < BN) begin
                    b_r_valid = 1'b1;
                    b_r_nz    = (rv[i] != 0);
                    b_r_neg   = (rv[i] < 0);
                end else begin
                    b_r_valid = 1'b0;
                end
                #1;
                if (b_r_valid && b_r_ready) i++;
                if (b_busy && !b_h_ready && !b_r_ready && !b_e_valid) sweeps++;
                g++;
            end
            b_r_valid = 1'b0;
            chk("big_r_beats", i, BN);
            chk("big_sweep_cycles", sweeps, nz * ((BN + BL - 1) / BL));
            i = 0; g = 0; done_cnt = 0;
            while (i < BN && g < 5000) begin
                @(negedge clk);
                b_e_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (b_e_valid && b_e_ready) begin
                    if (b_done) done_cnt++;
                    chk($sformatf("big_e[%0d]", i), b_e_data, ev[i]);
                    i++;
                end
                g++;
            end
            @(negedge clk);
            b_e_ready = 1'b0;
            #1;
            chk("big_drain_beats", i, BN);
            chk("big_done_count", done_cnt, 1);
            chk("big_busy_idle", b_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
